stage4_mem: RTL and testbench
=============================

Name: stage4_mem

Overview:
- Memory-access stage of the RV64IMFD pipeline, directly downstream of the execute stage.
- Consumes the execute-stage result bundle and drives the data-memory request/response handshake.
- Aligns and extends load data, and forwards the result to writeback as op_mem/rd_mem.
- Non-memory ops pass through in one cycle; memory ops stall the pipeline until the response arrives.

Parameters:
- XLEN, 64, data width.
- ADDR_W, 48, data address width.

Ports:
- clk  in  1  clock
- n_reset  in  1  asynchronous active-low reset
- valid_ex  in  1  execute bundle valid
- rd_ex  in  5  destination register
- op_ex  in  64  ALU result, or store data for stores
- we_rd_ex  in  1  register write enable
- mem_addr_ex  in  48  effective address
- reg_type_ex  in  1  0=integer, 1=FP register file
- type_op_mem_ex  in  5  memory op encoding
- trap_if_dec_ex, trap_dec_ex, trap_ex  in  1 each  upstream trap flags
- stall_mem  out  1  pipeline hold to upstream stages
- valid_mem, we_rd_mem, reg_type_mem  out  1 each  result bundle
- rd_mem  out  5  destination register
- op_mem  out  64  result data
- trap_mem  out  1  OR of upstream traps plus misalignment
- dmem_req, dmem_we  out  1 each  request, write
- dmem_addr  out  48  8-byte-aligned address
- dmem_be  out  8  byte enables
- dmem_wdata  out  64  lane-shifted store data
- dmem_gnt, dmem_rvalid  in  1 each  grant, response (stores also get rvalid as ack)
- dmem_rdata  in  64  read data

Behaviour:
- Clock and reset: single clock clk. n_reset is asynchronous, active-low.
- Reset values: every output is 0, FSM is IDLE.
- Encoding of type_op_mem:
  - bit4 = memory op; bit3 = store.
  - bits[2:0]: 000 B, 001 H, 010 W, 011 D, 100 BU, 101 HU, 110 WU.
  - Stores use bits[1:0] as size only.
- FSM states:
  - IDLE: accept when valid_ex.
  - REQ: dmem_req=1, hold addr/be/wdata/we stable until dmem_gnt.
  - WAIT: wait for dmem_rvalid.
- IDLE, non-memory op or any upstream trap:
  - Bundle registered next cycle: valid_mem=1, op_mem=op_ex.
  - No request issued. Stay in IDLE.
- IDLE, memory op:
  - Capture the bundle, go to REQ, assert stall_mem combinationally in the accept cycle.
  - stall_mem stays high through REQ and WAIT.
- REQ transitions: gnt=1 -> WAIT. If gnt and rvalid arrive in the same cycle -> complete directly.
- WAIT transitions: rvalid -> complete.
- Complete (registered, one cycle):
  - valid_mem=1; stall_mem drops in the same cycle; FSM returns to IDLE.
  - Load: op_mem = dmem_rdata shifted by addr[2:0]*8, then sign/zero-extended per size.
  - Store: we_rd_mem=0.
  - Minimum memory-op latency is 2 cycles from accept.
- valid_mem is a one-cycle pulse per accepted bundle. The held bundle is not re-accepted while stall_mem=1.
- Address and lanes:
  - dmem_addr = {addr[47:3],3'b000}.
  - dmem_be = size mask << addr[2:0].
  - dmem_wdata = op_ex << (addr[2:0]*8).
- Misalignment: address not a multiple of access size.
- FP loads: W with reg_type_ex=1 is NaN-boxed (upper 32 bits set to 1).
- Asserting n_reset mid-REQ/WAIT aborts the access immediately. dmem_req drops asynchronously and any late rvalid is ignored.

Optional Feature:
- Macro: MISALIGN_TRAP_EN.
- Defined: a misaligned access issues no request, sets trap_mem=1 and we_rd_mem=0, and completes next cycle.
- Undefined: the low address bits are masked to the access size (forced alignment) and the access proceeds normally. trap_mem reflects upstream traps only.

Decomposition:
- riscv_pkg holds:
  - mem_op_t encoding constants (MEM_B..MEM_WU, MEM_VALID_BIT, MEM_STORE_BIT).
  - mem_state_t enum {IDLE, REQ, WAIT}.
  - XLEN/ADDR_W defaults.
- One combinational sub-module, mem_load_align: inputs rdata, addr[2:0], type, reg_type; output aligned/extended value. Reused by the bench reference model.

Test Plan:
- Non-memory op: valid_ex=1, type=0, op_ex=0x1234, rd_ex=5 -> next cycle valid_mem=1, op_mem=0x1234, rd_mem=5, dmem_req never high.
- LB with sign extension: addr=0x103, gnt same cycle, rvalid next cycle, rdata=0x00000000_80000000 -> dmem_addr=0x100, dmem_be=0x08, op_mem=0xFFFFFFFFFFFFFF80.
- SH with lane shift: addr=0x206, op_ex=0xABCD, gnt delayed 3 cycles -> dmem_be=0xC0, dmem_wdata[63:48]=0xABCD, request signals stable throughout, stall_mem high until rvalid, we_rd_mem=0.
- LWU vs FP LW: rdata word 0x8000_0001 -> LWU gives op_mem=0x0000000080000001; LW with reg_type=1 gives 0xFFFFFFFF80000001.
- Misaligned LH at addr=0x101:
  - With MISALIGN_TRAP_EN: trap_mem=1, no dmem_req, stall released after 1 cycle.
  - Without: request is issued at byte 0x100.
- Reset during WAIT: n_reset low while waiting -> all outputs 0 immediately; a subsequent rvalid produces no valid_mem.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared encodings for the RV64 pipeline memory stage: op-type bits, FSM states, lane helpers.
package riscv_pkg;

    localparam int unsigned XLEN_DEFAULT   = 64;
    localparam int unsigned ADDR_W_DEFAULT = 48;

    typedef logic [2:0] mem_op_t;

    localparam int unsigned MEM_VALID_BIT = 4;
    localparam int unsigned MEM_STORE_BIT = 3;

    localparam mem_op_t MEM_B  = 3'b000;
    localparam mem_op_t MEM_H  = 3'b001;
    localparam mem_op_t MEM_W  = 3'b010;
    localparam mem_op_t MEM_D  = 3'b011;
    localparam mem_op_t MEM_BU = 3'b100;
    localparam mem_op_t MEM_HU = 3'b101;
    localparam mem_op_t MEM_WU = 3'b110;

    typedef logic [1:0] mem_state_t;

    localparam mem_state_t IDLE = 2'd0;
    localparam mem_state_t REQ  = 2'd1;
    localparam mem_state_t WAIT = 2'd2;

    // Byte-enable pattern for a lane-0 access of 1/2/4/8 bytes.
    function automatic logic [7:0] size_be(input logic [1:0] size);
        case (size)
            2'd0:    size_be = 8'h01;
            2'd1:    size_be = 8'h03;
            2'd2:    size_be = 8'h0f;
            default: size_be = 8'hff;
        endcase
    endfunction

    // Offset bits that must be zero for a naturally aligned access.
    function automatic logic [2:0] size_low(input logic [1:0] size);
        case (size)
            2'd0:    size_low = 3'b000;
            2'd1:    size_low = 3'b001;
            2'd2:    size_low = 3'b011;
            default: size_low = 3'b111;
        endcase
    endfunction

endpackage

// File: rtl/stage4_mem_load_align.sv
// Load data alignment: shift the returned doubleword down to the accessed lane, then extend.
module mem_load_align
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEFAULT
) (
    input  logic [XLEN-1:0] rdata,
    input  logic [2:0]      addr,
    input  mem_op_t         mem_type,
    input  logic            reg_type,
    output logic [XLEN-1:0] result
);

    logic [XLEN-1:0] shifted;

    always_comb begin
        shifted = rdata >> {addr, 3'b000};
        case (mem_type)
            MEM_B:   result = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
            MEM_BU:  result = {{(XLEN-8){1'b0}}, shifted[7:0]};
            MEM_H:   result = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
            MEM_HU:  result = {{(XLEN-16){1'b0}}, shifted[15:0]};
            // Single-precision FP values are NaN-boxed in the 64-bit FP register file
            MEM_W:   result = reg_type ? {{(XLEN-32){1'b1}}, shifted[31:0]}
                                       : {{(XLEN-32){shifted[31]}}, shifted[31:0]};
            MEM_WU:  result = {{(XLEN-32){1'b0}}, shifted[31:0]};
            default: result = shifted;
        endcase
    end

endmodule

// File: rtl/stage4_mem.sv
// Memory-access pipeline stage: drives the dmem handshake and forwards results to writeback.
// Optional MISALIGN_TRAP_EN: misaligned accesses trap instead of being force-aligned.
module stage4_mem
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN   = XLEN_DEFAULT,
    parameter int unsigned ADDR_W = ADDR_W_DEFAULT
) (
    input  logic              clk,
    input  logic              n_reset,
    input  logic              valid_ex,
    input  logic [4:0]        rd_ex,
    input  logic [XLEN-1:0]   op_ex,
    input  logic              we_rd_ex,
    input  logic [ADDR_W-1:0] mem_addr_ex,
    input  logic              reg_type_ex,
    input  logic [4:0]        type_op_mem_ex,
    input  logic              trap_if_dec_ex,
    input  logic              trap_dec_ex,
    input  logic              trap_ex,
    output logic              stall_mem,
    output logic              valid_mem,
    output logic              we_rd_mem,
    output logic              reg_type_mem,
    output logic [4:0]        rd_mem,
    output logic [XLEN-1:0]   op_mem,
    output logic              trap_mem,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [7:0]        dmem_be,
    output logic [XLEN-1:0]   dmem_wdata,
    input  logic              dmem_gnt,
    input  logic              dmem_rvalid,
    input  logic [XLEN-1:0]   dmem_rdata
);

    mem_state_t      state_q, state_d;
    logic            up_trap, is_mem, is_store, accept_mem, complete, mis_acc;
    logic [1:0]      size;
    logic [2:0]      lane, lane_q;
    mem_op_t         type_q;
    logic [4:0]      rd_q;
    logic            we_rd_q, reg_type_q, mis_q;
    logic [XLEN-1:0] op_q, load_val;

    assign up_trap  = trap_if_dec_ex | trap_dec_ex | trap_ex;
    assign is_mem   = type_op_mem_ex[MEM_VALID_BIT];
    assign is_store = type_op_mem_ex[MEM_STORE_BIT];
    assign size     = type_op_mem_ex[1:0];

`ifdef MISALIGN_TRAP_EN
    assign mis_acc = |(mem_addr_ex[2:0] & size_low(size));
    assign lane    = mem_addr_ex[2:0];
`else
    assign mis_acc = 1'b0;
    assign lane    = mem_addr_ex[2:0] & ~size_low(size);
`endif

    assign accept_mem = (state_q == IDLE) && valid_ex && is_mem && !up_trap;
    // A trapped misaligned access sits in REQ for one cycle without requesting
    assign complete   = ((state_q == REQ) && (mis_q || (dmem_gnt && dmem_rvalid)))
                     || ((state_q == WAIT) && dmem_rvalid);
    assign stall_mem  = n_reset && (accept_mem || ((state_q != IDLE) && !complete));
    assign dmem_req   = (state_q == REQ) && !mis_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept_mem) state_d = REQ;
            REQ:     if (complete) state_d = IDLE;
                     else if (dmem_gnt) state_d = WAIT;
            WAIT:    if (dmem_rvalid) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    mem_load_align #(
        .XLEN (XLEN)
    ) u_load_align (
        .rdata    (dmem_rdata),
        .addr     (lane_q),
        .mem_type (type_q),
        .reg_type (reg_type_q),
        .result   (load_val)
    );

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q      <= IDLE;
            valid_mem    <= 1'b0;
            we_rd_mem    <= 1'b0;
            reg_type_mem <= 1'b0;
            rd_mem       <= '0;
            op_mem       <= '0;
            trap_mem     <= 1'b0;
            dmem_we      <= 1'b0;
            dmem_addr    <= '0;
            dmem_be      <= '0;
            dmem_wdata   <= '0;
            lane_q       <= '0;
            type_q       <= '0;
            rd_q         <= '0;
            we_rd_q      <= 1'b0;
            reg_type_q   <= 1'b0;
            op_q         <= '0;
            mis_q        <= 1'b0;
        end else begin
            state_q   <= state_d;
            valid_mem <= 1'b0;
            if (accept_mem) begin
                dmem_addr  <= {mem_addr_ex[ADDR_W-1:3], 3'b000};
                dmem_be    <= size_be(size) << lane;
                dmem_wdata <= op_ex << {lane, 3'b000};
                dmem_we    <= is_store;
                lane_q     <= lane;
                type_q     <= type_op_mem_ex[2:0];
                rd_q       <= rd_ex;
                we_rd_q    <= we_rd_ex && !is_store;
                reg_type_q <= reg_type_ex;
                op_q       <= op_ex;
                mis_q      <= mis_acc;
            end else if ((state_q == IDLE) && valid_ex) begin
                valid_mem    <= 1'b1;
                rd_mem       <= rd_ex;
                op_mem       <= op_ex;
                we_rd_mem    <= we_rd_ex;
                reg_type_mem <= reg_type_ex;
                trap_mem     <= up_trap;
            end
            if (complete) begin
                valid_mem    <= 1'b1;
                rd_mem       <= rd_q;
                reg_type_mem <= reg_type_q;
                trap_mem     <= mis_q;
                we_rd_mem    <= we_rd_q && !mis_q;
                op_mem       <= dmem_we ? op_q : load_val;
            end
        end
    end

endmodule

// File: tb/tb_stage4_mem.sv
// Self-checking bench for stage4_mem with a behavioural lane/extension reference model.
module tb_stage4_mem;

    logic        clk = 1'b0;
    logic        n_reset;
    logic        valid_ex, we_rd_ex, reg_type_ex;
    logic [4:0]  rd_ex, type_op_mem_ex;
    logic [63:0] op_ex, dmem_rdata;
    logic [47:0] mem_addr_ex;
    logic        trap_if_dec_ex, trap_dec_ex, trap_ex;
    logic        stall_mem, valid_mem, we_rd_mem, reg_type_mem, trap_mem;
    logic [4:0]  rd_mem;
    logic [63:0] op_mem, dmem_wdata;
    logic        dmem_req, dmem_we, dmem_gnt, dmem_rvalid;
    logic [47:0] dmem_addr;
    logic [7:0]  dmem_be;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    stage4_mem dut (
        .clk            (clk),
        .n_reset        (n_reset),
        .valid_ex       (valid_ex),
        .rd_ex          (rd_ex),
        .op_ex          (op_ex),
        .we_rd_ex       (we_rd_ex),
        .mem_addr_ex    (mem_addr_ex),
        .reg_type_ex    (reg_type_ex),
        .type_op_mem_ex (type_op_mem_ex),
        .trap_if_dec_ex (trap_if_dec_ex),
        .trap_dec_ex    (trap_dec_ex),
        .trap_ex        (trap_ex),
        .stall_mem      (stall_mem),
        .valid_mem      (valid_mem),
        .we_rd_mem      (we_rd_mem),
        .reg_type_mem   (reg_type_mem),
        .rd_mem         (rd_mem),
        .op_mem         (op_mem),
        .trap_mem       (trap_mem),
        .dmem_req       (dmem_req),
        .dmem_we        (dmem_we),
        .dmem_addr      (dmem_addr),
        .dmem_be        (dmem_be),
        .dmem_wdata     (dmem_wdata),
        .dmem_gnt       (dmem_gnt),
        .dmem_rvalid    (dmem_rvalid),
        .dmem_rdata     (dmem_rdata)
    );

    // ---------------- reference model ----------------
    function automatic int nbytes(input logic [1:0] s);
        return 1 << s;
    endfunction

    function automatic logic m_misaligned(input logic [47:0] a, input logic [1:0] s);
`ifdef MISALIGN_TRAP_EN
        return (int'(a[2:0]) % nbytes(s)) != 0;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [47:0] m_eff_addr(input logic [47:0] a, input logic [1:0] s);
`ifdef MISALIGN_TRAP_EN
        return a;
`else
        return a - 48'(int'(a[2:0]) % nbytes(s));
`endif
    endfunction

    function automatic logic [63:0] m_load(input logic [63:0] rdata, input logic [47:0] a,
                                           input logic [4:0] t, input logic fp);
        int n;
        int lane;
        logic [63:0] v, mask;
        n    = nbytes(t[1:0]);
        lane = int'(a[2:0]);
        v    = rdata >> (lane * 8);
        if (n == 8) return v;
        mask = (64'd1 << (n * 8)) - 64'd1;
        v    = v & mask;
        if (n == 4 && fp && !t[2]) return v | ~mask;
        if (t[2]) return v;
        if (v[n*8-1]) return v | ~mask;
        return v;
    endfunction

    // ---------------- stimulus tasks ----------------
    task automatic drive_bundle(input logic [4:0] t, input logic [47:0] a, input logic [63:0] d,
                                input logic fp, input logic [4:0] rd, input logic we);
        valid_ex = 1'b1; type_op_mem_ex = t; mem_addr_ex = a; op_ex = d;
        reg_type_ex = fp; rd_ex = rd; we_rd_ex = we;
        trap_if_dec_ex = 1'b0; trap_dec_ex = 1'b0; trap_ex = 1'b0;
    endtask

    task automatic do_alu(input string name, input logic [4:0] t, input logic [63:0] d,
                          input logic [4:0] rd, input logic [2:0] traps);
        drive_bundle(t, 48'h0, d, 1'b0, rd, 1'b1);
        {trap_if_dec_ex, trap_dec_ex, trap_ex} = traps;
        #1;
        checks++; if (stall_mem !== 1'b0 || dmem_req !== 1'b0) begin errors++;
            $display("FAIL %s accept stall/req got %b/%b want 0/0", name, stall_mem, dmem_req); end
        @(posedge clk); #1;
        valid_ex = 1'b0;
        checks++; if (valid_mem !== 1'b1 || op_mem !== d || rd_mem !== rd || we_rd_mem !== 1'b1)
            begin errors++; $display("FAIL %s result got v=%b op=%h rd=%0d we=%b want 1 %h %0d 1",
                name, valid_mem, op_mem, rd_mem, we_rd_mem, d, rd); end
        checks++; if (trap_mem !== (|traps) || dmem_req !== 1'b0) begin errors++;
            $display("FAIL %s trap/req got %b/%b want %b/0", name, trap_mem, dmem_req, |traps); end
        @(posedge clk); #1;
        checks++; if (valid_mem !== 1'b0) begin errors++;
            $display("FAIL %s pulse got valid_mem=%b want 0", name, valid_mem); end
    endtask

    task automatic do_mem(input string name, input logic [4:0] t, input logic [47:0] a,
                          input logic [63:0] d, input logic fp, input logic [4:0] rd,
                          input logic we, input int gnt_dly, input int rv_dly,
                          input logic [63:0] rdata);
        logic        st, mis;
        logic [47:0] ea, x_addr;
        logic [7:0]  x_be;
        logic [63:0] x_wdata;
        st      = t[3];
        mis     = m_misaligned(a, t[1:0]);
        ea      = m_eff_addr(a, t[1:0]);
        x_addr  = ea & ~48'h7;
        x_be    = 8'(((16'd1 << nbytes(t[1:0])) - 16'd1) << ea[2:0]);
        x_wdata = d << (int'(ea[2:0]) * 8);
        drive_bundle(t, a, d, fp, rd, we);
        #1;
        checks++; if (stall_mem !== 1'b1 || dmem_req !== 1'b0) begin errors++;
            $display("FAIL %s accept stall/req got %b/%b want 1/0", name, stall_mem, dmem_req); end
        @(posedge clk); #1;
        if (mis) begin
            checks++; if (dmem_req !== 1'b0 || stall_mem !== 1'b0) begin errors++;
                $display("FAIL %s misalign req/stall got %b/%b want 0/0", name, dmem_req, stall_mem); end
            @(posedge clk); #1;
            valid_ex = 1'b0;
            checks++; if (valid_mem !== 1'b1 || trap_mem !== 1'b1 || we_rd_mem !== 1'b0) begin
                errors++; $display("FAIL %s misalign result got v=%b trap=%b we=%b want 1 1 0",
                    name, valid_mem, trap_mem, we_rd_mem); end
        end else begin
            for (int i = 0; i <= gnt_dly; i++) begin
                checks++; if (dmem_req !== 1'b1 || dmem_addr !== x_addr || dmem_be !== x_be ||
                              dmem_we !== st || stall_mem !== 1'b1 ||
                              (st && dmem_wdata !== x_wdata)) begin errors++;
                    $display("FAIL %s req cyc%0d got req=%b a=%h be=%h we=%b wd=%h st=%b want 1 %h %h %b %h 1",
                        name, i, dmem_req, dmem_addr, dmem_be, dmem_we, dmem_wdata, stall_mem,
                        x_addr, x_be, st, x_wdata); end
                if (i < gnt_dly) begin @(posedge clk); #1; end
            end
            dmem_gnt = 1'b1;
            if (rv_dly == 0) begin dmem_rvalid = 1'b1; dmem_rdata = rdata; end
            #1;
            checks++; if (stall_mem !== (rv_dly != 0)) begin errors++;
                $display("FAIL %s gnt stall got %b want %b", name, stall_mem, rv_dly != 0); end
            @(posedge clk); #1;
            dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
            if (rv_dly != 0) begin
                for (int i = 1; i < rv_dly; i++) begin
                    checks++; if (stall_mem !== 1'b1 || dmem_req !== 1'b0) begin errors++;
                        $display("FAIL %s wait stall/req got %b/%b want 1/0", name, stall_mem, dmem_req); end
                    @(posedge clk); #1;
                end
                dmem_rvalid = 1'b1; dmem_rdata = rdata;
                #1;
                checks++; if (stall_mem !== 1'b0) begin errors++;
                    $display("FAIL %s rvalid stall got %b want 0", name, stall_mem); end
                @(posedge clk); #1;
                dmem_rvalid = 1'b0;
            end
            valid_ex = 1'b0;
            checks++; if (valid_mem !== 1'b1 || rd_mem !== rd || we_rd_mem !== (we && !st) ||
                          trap_mem !== 1'b0 || reg_type_mem !== fp) begin errors++;
                $display("FAIL %s result got v=%b rd=%0d we=%b trap=%b rt=%b want 1 %0d %b 0 %b",
                    name, valid_mem, rd_mem, we_rd_mem, trap_mem, reg_type_mem, rd, we && !st, fp); end
            if (!st) begin
                checks++; if (op_mem !== m_load(rdata, ea, t, fp)) begin errors++;
                    $display("FAIL %s load data got %h want %h", name, op_mem, m_load(rdata, ea, t, fp)); end
            end
        end
        @(posedge clk); #1;
        checks++; if (valid_mem !== 1'b0 || stall_mem !== 1'b0) begin errors++;
            $display("FAIL %s after got valid/stall %b/%b want 0/0", name, valid_mem, stall_mem); end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        #1;
        checks++; if ({stall_mem, valid_mem, we_rd_mem, reg_type_mem, trap_mem, dmem_req, dmem_we}
                      !== 7'b0 || rd_mem !== 5'd0 || op_mem !== 64'd0 || dmem_addr !== 48'd0 ||
                      dmem_be !== 8'd0 || dmem_wdata !== 64'd0) begin errors++;
            $display("FAIL reset outputs not all zero: v=%b st=%b req=%b op=%h a=%h be=%h",
                valid_mem, stall_mem, dmem_req, op_mem, dmem_addr, dmem_be); end
        @(posedge clk); #1;
        n_reset = 1'b1;
        @(posedge clk); #1;
        checks++; if (valid_mem !== 1'b0 || stall_mem !== 1'b0) begin errors++;
            $display("FAIL reset_release got valid/stall %b/%b want 0/0", valid_mem, stall_mem); end
    endtask

    task automatic test_passthrough();
        do_alu("alu_1234", 5'b00000, 64'h1234, 5'd5, 3'b000);
        do_alu("alu_rand", 5'b00111, {$urandom(), $urandom()}, 5'd17, 3'b000);
        do_alu("trap_memop", 5'b10011, 64'hdead_beef, 5'd9, 3'b010);
        do_alu("trap_if", 5'b00000, 64'h55, 5'd1, 3'b100);
    endtask

    task automatic test_lb();
        do_mem("lb_sext", 5'b10000, 48'h103, 64'h0, 1'b0, 5'd7, 1'b1, 0, 1,
               64'h0000_0000_8000_0000);
    endtask

    task automatic test_sh();
        do_mem("sh_lane", 5'b11001, 48'h206, 64'hABCD, 1'b0, 5'd3, 1'b1, 3, 1, 64'h0);
    endtask

    task automatic test_lwu_flw();
        do_mem("lwu", 5'b10110, 48'h400, 64'h0, 1'b0, 5'd10, 1'b1, 0, 0, 64'h0000_0000_8000_0001);
        do_mem("flw", 5'b10010, 48'h400, 64'h0, 1'b1, 5'd11, 1'b1, 1, 2, 64'h0000_0000_8000_0001);
    endtask

    task automatic test_misaligned();
        do_mem("lh_mis", 5'b10001, 48'h101, 64'h0, 1'b0, 5'd12, 1'b1, 0, 1, 64'h1122_3344_5566_7788);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 40; i++) begin
            logic [4:0]  t;
            logic [47:0] a;
            logic [63:0] d, r;
            a = {16'($urandom()), 32'($urandom())};
            d = {$urandom(), $urandom()};
            r = {$urandom(), $urandom()};
            if ($urandom_range(0, 3) == 0) begin
                do_alu("rand_alu", 5'($urandom_range(0, 15)), d, 5'($urandom()), 3'b000);
            end else begin
                if ($urandom_range(0, 1) == 1) t = {2'b11, 1'b0, 2'($urandom_range(0, 3))};
                else t = {2'b10, 3'($urandom_range(0, 6))};
                do_mem("rand_mem", t, a, d, 1'($urandom()), 5'($urandom()), 1'($urandom()),
                       $urandom_range(0, 3), $urandom_range(0, 3), r);
            end
        end
    endtask

    task automatic test_reset_wait();
        drive_bundle(5'b10011, 48'h300, 64'h0, 1'b0, 5'd20, 1'b1);
        @(posedge clk); #1;
        dmem_gnt = 1'b1;
        @(posedge clk); #1;
        dmem_gnt = 1'b0;
        n_reset = 1'b0;
        #1;
        checks++; if (dmem_req !== 1'b0 || stall_mem !== 1'b0 || valid_mem !== 1'b0 ||
                      op_mem !== 64'd0 || rd_mem !== 5'd0 || dmem_addr !== 48'd0 ||
                      dmem_be !== 8'd0 || dmem_we !== 1'b0) begin errors++;
            $display("FAIL reset_wait outputs got req=%b st=%b v=%b op=%h rd=%0d a=%h be=%h",
                dmem_req, stall_mem, valid_mem, op_mem, rd_mem, dmem_addr, dmem_be); end
        valid_ex = 1'b0;
        @(posedge clk); #1;
        n_reset = 1'b1;
        dmem_rvalid = 1'b1; dmem_rdata = 64'hffff_ffff_ffff_ffff;
        @(posedge clk); #1;
        dmem_rvalid = 1'b0;
        checks++; if (valid_mem !== 1'b0 || stall_mem !== 1'b0) begin errors++;
            $display("FAIL late_rvalid got valid/stall %b/%b want 0/0", valid_mem, stall_mem); end
        @(posedge clk); #1;
        checks++; if (valid_mem !== 1'b0 || dmem_req !== 1'b0) begin errors++;
            $display("FAIL late_rvalid2 got valid/req %b/%b want 0/0", valid_mem, dmem_req); end
    endtask

    initial begin
        n_reset = 1'b0;
        valid_ex = 1'b0; rd_ex = '0; op_ex = '0; we_rd_ex = 1'b0; mem_addr_ex = '0;
        reg_type_ex = 1'b0; type_op_mem_ex = '0;
        trap_if_dec_ex = 1'b0; trap_dec_ex = 1'b0; trap_ex = 1'b0;
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
        repeat (3) @(posedge clk);
        test_reset();
        test_passthrough();
        test_lb();
        test_sh();
        test_lwu_flw();
        test_misaligned();
        test_back_to_back();
        test_reset_wait();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout simulation did not finish within bound");
        $fatal(1, "timeout");
    end

endmodule
